// File: rtl/zone_data_serializer.sv
// -----------------------------------------------------------------------------
// zone_data_serializer
//
// Replays a vector of per-zone backlight values along the active line, so
// every pixel can look up the value of the zone it falls in. The block keeps
// its own horizontal pixel counter and captures the zone vector at line start.
// Because of that capture, the vector may change mid-line without tearing.
//
// Ports
//   iODCK      pixel clock; all logic runs on the rising edge
//   iRST       synchronous active-high reset
//   iDE        data enable; high during the active pixels of a line
//   iZoneData  ZONES*DW zone vector; lane z = bits [DW*z+DW-1 : DW*z]
//   oZoneY     zone value for the pixel presented one cycle earlier
//   oValid     oZoneY qualifier (iDE delayed one cycle, low past the line end)
//   oZoneIdx   zone index of the pixel on oZoneY
//   oLineDone  one-cycle pulse after a line ends
//   oOverrun   one-cycle pulse on the first pixel beyond ZONES*ZONE_W
// -----------------------------------------------------------------------------
module zone_data_serializer #(
   parameter  int ZONES  = 24,
   parameter  int ZONE_W = 80,
   parameter  int DW     = 8,
   localparam int ZIW    = $clog2(ZONES)
) (
   input  logic                  iODCK,
   input  logic                  iRST,
   input  logic                  iDE,
   input  logic [ZONES*DW-1:0]   iZoneData,
   output logic [DW-1:0]         oZoneY,
   output logic                  oValid,
   output logic [ZIW-1:0]        oZoneIdx,
   output logic                  oLineDone,
   output logic                  oOverrun
);

   localparam int PW = $clog2(ZONE_W);
   localparam logic [PW-1:0]  PIX_LAST  = PW'(ZONE_W - 1);
   localparam logic [PW-1:0]  PIX_ONE   = PW'(1);
   localparam logic [ZIW-1:0] ZONE_LAST = ZIW'(ZONES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_OVER   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  de_q, de_d;
   logic [ZONES*DW-1:0]   shadow_q, shadow_d;
   logic [PW-1:0]         pix_q, pix_d;
   logic [ZIW-1:0]        zone_q, zone_d;
   logic                  over_seen_q, over_seen_d;
   logic [DW-1:0]         zone_y_q, zone_y_d;
   logic                  valid_q, valid_d;
   logic [ZIW-1:0]        idx_q, idx_d;
   logic                  done_q, done_d;
   logic                  overrun_q, overrun_d;
   logic                  line_start;

   // Captured vector split into lanes for the per-pixel lookup.
   logic [DW-1:0] lane [ZONES];

   generate
      for (genvar gi = 0; gi < ZONES; gi++) begin : g_lane
         assign lane[gi] = shadow_q[gi*DW +: DW];
      end
   endgenerate

   // A rising iDE starts a line from any state, so a short line or an
   // overrun never leaves residue in the counters.
   assign line_start = iDE & ~de_q;

   always_comb begin
      state_d     = state_q;
      de_d        = iDE;
      shadow_d    = shadow_q;
      pix_d       = pix_q;
      zone_d      = zone_q;
      over_seen_d = over_seen_q;
      zone_y_d    = zone_y_q;
      valid_d     = 1'b0;
      idx_d       = idx_q;
      done_d      = 1'b0;
      overrun_d   = 1'b0;

      if (!iDE) begin
         // oZoneY and oZoneIdx keep their last values between lines.
         state_d = S_IDLE;
         done_d  = de_q;
      end else if (line_start) begin
         // Pixel 0 bypasses the shadow so it already sees the fresh vector.
         shadow_d    = iZoneData;
         pix_d       = PIX_ONE;
         zone_d      = '0;
         state_d     = S_ACTIVE;
         over_seen_d = 1'b0;
         zone_y_d    = iZoneData[DW-1:0];
         idx_d       = '0;
         valid_d     = 1'b1;
      end else begin
         case (state_q)
            S_ACTIVE: begin
               zone_y_d = lane[zone_q];
               idx_d    = zone_q;
               valid_d  = 1'b1;
               if (pix_q == PIX_LAST) begin
                  if (zone_q == ZONE_LAST) begin
                     // Last pixel of the line: hold counters, flag overflow.
                     state_d = S_OVER;
                  end else begin
                     pix_d  = '0;
                     zone_d = zone_q + 1'b1;
                  end
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
            S_OVER: begin
               zone_y_d    = '0;
               idx_d       = ZONE_LAST;
               overrun_d   = ~over_seen_q;
               over_seen_d = 1'b1;
            end
            default: begin
               // IDLE with iDE high and no rising edge cannot follow a
               // normal line; output nothing until the next line start.
            end
         endcase
      end
   end

   always_ff @(posedge iODCK) begin
      if (iRST) begin
         state_q     <= S_IDLE;
         de_q        <= 1'b0;
         shadow_q    <= '0;
         pix_q       <= '0;
         zone_q      <= '0;
         over_seen_q <= 1'b0;
         zone_y_q    <= '0;
         valid_q     <= 1'b0;
         idx_q       <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         de_q        <= de_d;
         shadow_q    <= shadow_d;
         pix_q       <= pix_d;
         zone_q      <= zone_d;
         over_seen_q <= over_seen_d;
         zone_y_q    <= zone_y_d;
         valid_q     <= valid_d;
         idx_q       <= idx_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   assign oZoneY    = zone_y_q;
   assign oValid    = valid_q;
   assign oZoneIdx  = idx_q;
   assign oLineDone = done_q;
   assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_zone_data_serializer.sv
// -----------------------------------------------------------------------------
// tb_zone_data_serializer
//
// Directed bench for zone_data_serializer. A segment table covers reset and a
// short line followed by a one-cycle gap. Hand-written sequences cover the full
// line, a mid-line vector change, overrun, reset mid-line and the zone 0/1
// boundary. Expected values come from the stimulus vectors held by the bench.
// -----------------------------------------------------------------------------
module tb_zone_data_serializer;

   localparam int ZONES  = 24;
   localparam int ZONE_W = 80;
   localparam int DW     = 8;
   localparam int NPIX   = ZONES * ZONE_W;

   logic                  iODCK = 1'b0;
   logic                  iRST;
   logic                  iDE;
   logic [ZONES*DW-1:0]   iZoneData;
   logic [DW-1:0]         oZoneY;
   logic                  oValid;
   logic [4:0]            oZoneIdx;
   logic                  oLineDone;
   logic                  oOverrun;

   int total = 0;
   int bad   = 0;

   zone_data_serializer #(
      .ZONES  (ZONES),
      .ZONE_W (ZONE_W),
      .DW     (DW)
   ) dut (
      .iODCK     (iODCK),
      .iRST      (iRST),
      .iDE       (iDE),
      .iZoneData (iZoneData),
      .oZoneY    (oZoneY),
      .oValid    (oValid),
      .oZoneIdx  (oZoneIdx),
      .oLineDone (oLineDone),
      .oOverrun  (oOverrun)
   );

   always #5 iODCK = ~iODCK;

   typedef struct {
      logic       rst;
      logic       de;
      int         cycles;
      logic [7:0] ey;
      logic       ev;
      logic [4:0] eidx;
      logic       idx_care;
      logic       edone;
      logic       eover;
   } seg_t;

   seg_t segs [6];

   task automatic chk(input string name, input int n,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s pix=%0d got=%0h want=%0h", name, n, act, exp);
      end
   endtask

   function automatic logic [7:0] lane(input logic [ZONES*DW-1:0] d, input int z);
      return d[z*DW +: DW];
   endfunction

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge iODCK);
      #1;
   endtask

   // Check the outputs for pixel n of a line captured with vector d.
   task automatic check_pix(input int n, input logic [ZONES*DW-1:0] d);
      if (n < NPIX) begin
         chk("y", n, 32'(oZoneY), 32'(lane(d, n / ZONE_W)));
         chk("valid", n, 32'(oValid), 32'd1);
         chk("idx", n, 32'(oZoneIdx), 32'(n / ZONE_W));
         chk("over", n, 32'(oOverrun), 32'd0);
      end else begin
         chk("y_over", n, 32'(oZoneY), 32'd0);
         chk("valid_over", n, 32'(oValid), 32'd0);
         chk("idx_over", n, 32'(oZoneIdx), 32'd23);
         chk("over_pulse", n, 32'(oOverrun), (n == NPIX) ? 32'd1 : 32'd0);
      end
      chk("done", n, 32'(oLineDone), 32'd0);
   endtask

   // Drop iDE for two cycles and check the line-done pulse.
   task automatic end_line(input logic [7:0] yhold);
      iDE = 1'b0;
      tick();
      chk("ld_valid", -1, 32'(oValid), 32'd0);
      chk("ld_done", -1, 32'(oLineDone), 32'd1);
      chk("ld_yhold", -1, 32'(oZoneY), 32'(yhold));
      chk("ld_over", -1, 32'(oOverrun), 32'd0);
      tick();
      chk("ld_done_off", -1, 32'(oLineDone), 32'd0);
   endtask

   // Run a line of len pixels; from pixel chg onward (if chg >= 0) the input
   // vector switches to d2, which must not affect the captured line.
   task automatic run_line(input int len, input logic [ZONES*DW-1:0] d,
                           input int chg, input logic [ZONES*DW-1:0] d2);
      for (int n = 0; n < len; n++) begin
         iZoneData = (chg >= 0 && n >= chg) ? d2 : d;
         iDE       = 1'b1;
         tick();
         check_pix(n, d);
      end
      end_line((len > NPIX) ? 8'h00 : lane(d, (len - 1) / ZONE_W));
   endtask

   initial begin
      logic [ZONES*DW-1:0] d_tab, d_inc, d_ff, d_ab, d_rs, d_b;

      iRST      = 1'b1;
      iDE       = 1'b0;
      iZoneData = '0;

      d_tab = '0;
      d_tab[7:0]  = 8'h11;
      d_tab[15:8] = 8'h22;
      for (int z = 0; z < ZONES; z++) d_inc[z*DW +: DW] = 8'(z + 1);
      d_ff = '1;
      d_ab = d_inc;
      d_ab[191:184] = 8'hAB;
      d_rs = d_inc;
      d_rs[7:0] = 8'h77;
      d_b = '0;
      d_b[7:0]  = 8'h5A;
      d_b[15:8] = 8'hA5;

      //            rst   de    cyc  ey     ev    eidx  care  done  over
      segs[0] = '{1'b1, 1'b0,  3, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
      segs[1] = '{1'b0, 1'b1, 80, 8'h11, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
      segs[2] = '{1'b0, 1'b1, 20, 8'h22, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
      segs[3] = '{1'b0, 1'b0,  1, 8'h22, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
      segs[4] = '{1'b0, 1'b1, 80, 8'h11, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
      segs[5] = '{1'b0, 1'b1, 80, 8'h22, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};

      // Reset, then a 100-pixel line, a 1-cycle gap and the next line start.
      iZoneData = d_tab;
      for (int s = 0; s < 6; s++) begin
         for (int c = 0; c < segs[s].cycles; c++) begin
            iRST = segs[s].rst;
            iDE  = segs[s].de;
            tick();
            chk($sformatf("seg%0d_y", s), c, 32'(oZoneY), 32'(segs[s].ey));
            chk($sformatf("seg%0d_valid", s), c, 32'(oValid), 32'(segs[s].ev));
            if (segs[s].idx_care)
               chk($sformatf("seg%0d_idx", s), c, 32'(oZoneIdx), 32'(segs[s].eidx));
            chk($sformatf("seg%0d_done", s), c, 32'(oLineDone), 32'(segs[s].edone));
            chk($sformatf("seg%0d_over", s), c, 32'(oOverrun), 32'(segs[s].eover));
         end
      end
      // Remainder of the second table line: lanes 2..23 are zero.
      for (int n = 160; n < NPIX; n++) begin
         iDE = 1'b1;
         tick();
         check_pix(n, d_tab);
      end
      end_line(lane(d_tab, 23));

      // Full line with lanes 0x01..0x18.
      run_line(NPIX, d_inc, -1, '0);

      // Vector switches to all 0xFF at pixel 500; next line shows 0xFF.
      run_line(NPIX, d_inc, 500, d_ff);
      run_line(NPIX, d_ff, -1, '0);

      // 1925-pixel line: overrun pulse and blanked output past pixel 1919.
      run_line(NPIX + 5, d_ab, -1, '0);

      // Reset asserted at pixel 1000 with iDE still high.
      iZoneData = d_inc;
      for (int n = 0; n < 1000; n++) begin
         iDE = 1'b1;
         tick();
         check_pix(n, d_inc);
      end
      iRST = 1'b1;
      iDE  = 1'b1;
      tick();
      chk("rst_y", 1000, 32'(oZoneY), 32'd0);
      chk("rst_valid", 1000, 32'(oValid), 32'd0);
      chk("rst_idx", 1000, 32'(oZoneIdx), 32'd0);
      chk("rst_done", 1000, 32'(oLineDone), 32'd0);
      chk("rst_over", 1000, 32'(oOverrun), 32'd0);
      iRST = 1'b0;
      iZoneData = d_rs;
      for (int n = 0; n < 100; n++) begin
         iDE = 1'b1;
         tick();
         check_pix(n, d_rs);
      end
      end_line(lane(d_rs, 1));

      // Zone 0/1 boundary: pixel 79 -> 0x5A, pixel 80 -> 0xA5.
      iZoneData = d_b;
      for (int n = 0; n < NPIX; n++) begin
         iDE = 1'b1;
         tick();
         if (n == 79) chk("edge79", n, 32'(oZoneY), 32'h5A);
         if (n == 80) chk("edge80", n, 32'(oZoneY), 32'hA5);
         chk("edge_valid", n, 32'(oValid), 32'd1);
      end
      end_line(8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
